// File: rtl/ara_eoc_regs_pkg.sv
// ---------------------------------------------------------------------------
// ara_eoc_regs_pkg
// Shared definitions for the end-of-computation register responder:
//   - register indices (address bits [4:3])
//   - AXI response encodings
//   - VCD trigger command words
//   - write / read channel FSM state encodings
// ---------------------------------------------------------------------------
package ara_eoc_regs_pkg;

   // Register byte offsets and the word index derived from addr[4:3]
   localparam logic [7:0] OFF_EXIT          = 8'h00;
   localparam logic [7:0] OFF_EVENT_TRIGGER = 8'h08;
   localparam logic [7:0] OFF_DRAM_END      = 8'h10;
   localparam logic [7:0] OFF_CYCLE         = 8'h18;

   localparam logic [1:0] REG_EXIT          = OFF_EXIT[4:3];
   localparam logic [1:0] REG_EVENT_TRIGGER = OFF_EVENT_TRIGGER[4:3];
   localparam logic [1:0] REG_DRAM_END      = OFF_DRAM_END[4:3];
   localparam logic [1:0] REG_CYCLE         = OFF_CYCLE[4:3];

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } axi_resp_t;

   localparam logic [63:0] VCD_TRIGGER_ON  = 64'h1;
   localparam logic [63:0] VCD_TRIGGER_OFF = '1;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } r_state_t;

endpackage

// File: rtl/ara_eoc_wjoin.sv
// ---------------------------------------------------------------------------
// ara_eoc_wjoin
// AXI4-Lite write-address / write-data capture and join, plus the B channel
// state machine. AW and W are accepted independently; once both are present
// (held from an earlier cycle or handshaking this cycle) fire_o pulses for one
// cycle and the FSM waits in W_RESP until the response is accepted.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   awaddr_i/awvalid_i/awready_o   write-address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  write-data channel
//   bvalid_o/bready_i         write-response handshake
//   addr_o/data_o/strb_o      joined write (held value or live input)
//   fire_o                    one-cycle pulse: register update this edge
// ---------------------------------------------------------------------------
module ara_eoc_wjoin
   import ara_eoc_regs_pkg::*;
#(
   parameter int unsigned AddrWidth = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] awaddr_i,
   input  logic                 awvalid_i,
   output logic                 awready_o,
   input  logic [63:0]          wdata_i,
   input  logic [7:0]           wstrb_i,
   input  logic                 wvalid_i,
   output logic                 wready_o,
   output logic                 bvalid_o,
   input  logic                 bready_i,
   output logic [AddrWidth-1:0] addr_o,
   output logic [63:0]          data_o,
   output logic [7:0]           strb_o,
   output logic                 fire_o
);

   w_state_t             r_state;
   w_state_t             w_state_next;
   logic                 r_aw_held;
   logic                 r_w_held;
   logic [AddrWidth-1:0] r_addr;
   logic [63:0]          r_data;
   logic [7:0]           r_strb;

   always_comb begin
      w_state_next = r_state;
      awready_o    = 1'b0;
      wready_o     = 1'b0;
      bvalid_o     = 1'b0;
      fire_o       = 1'b0;
      case (r_state)
         W_IDLE: begin
            awready_o = !r_aw_held;
            wready_o  = !r_w_held;
            // A channel not yet held can only be "present" through a
            // handshake this cycle, since its ready is high.
            if ((r_aw_held || awvalid_i) && (r_w_held || wvalid_i)) begin
               fire_o       = 1'b1;
               w_state_next = W_RESP;
            end
         end
         W_RESP: begin
            bvalid_o = 1'b1;
            if (bready_i) begin
               w_state_next = W_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_strb    <= '0;
      end else begin
         r_state <= w_state_next;
         if (awvalid_i && awready_o) begin
            r_aw_held <= 1'b1;
            r_addr    <= awaddr_i;
         end
         if (wvalid_i && wready_o) begin
            r_w_held <= 1'b1;
            r_data   <= wdata_i;
            r_strb   <= wstrb_i;
         end
         if ((r_state == W_RESP) && bready_i) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   // Bypass so the update can happen on the very edge of the last handshake
   assign addr_o = r_aw_held ? r_addr : awaddr_i;
   assign data_o = r_w_held  ? r_data : wdata_i;
   assign strb_o = r_w_held  ? r_strb : wstrb_i;

endmodule

// File: rtl/ara_eoc_regs.sv
// ---------------------------------------------------------------------------
// ara_eoc_regs
// Memory-mapped end-of-computation / control register responder on an
// AXI4-Lite slave port (64-bit data).
//   0x00 EXIT           RW, sticky once bit 0 is set (drives exit_o)
//   0x08 EVENT_TRIGGER  RW, VCD dump trigger (drives event_trigger_o)
//   0x10 DRAM_END       RO, DRAMBase + DRAMLength
//   0x18 CYCLE          RO, free-running cycle counter
// Only addr[4:3] is decoded.
//
// Build option: ARA_EOC_EVENT_TRIGGER_EN. When undefined the EVENT_TRIGGER
// register is absent: event_trigger_o is 0, writes to 0x08 return SLVERR and
// reads return 0.
//
// Ports: clk_i, rst_ni (async active-low); AXI4-Lite AW/W/B/AR/R channels;
// exit_o and event_trigger_o registered control outputs.
// ---------------------------------------------------------------------------
module ara_eoc_regs
   import ara_eoc_regs_pkg::*;
#(
   parameter logic [63:0] DRAMBase   = 64'h8000_0000,
   parameter logic [63:0] DRAMLength = 64'h4000_0000,
   parameter int unsigned AddrWidth  = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] awaddr_i,
   input  logic                 awvalid_i,
   output logic                 awready_o,
   input  logic [63:0]          wdata_i,
   input  logic [7:0]           wstrb_i,
   input  logic                 wvalid_i,
   output logic                 wready_o,
   output logic [1:0]           bresp_o,
   output logic                 bvalid_o,
   input  logic                 bready_i,
   input  logic [AddrWidth-1:0] araddr_i,
   input  logic                 arvalid_i,
   output logic                 arready_o,
   output logic [63:0]          rdata_o,
   output logic [1:0]           rresp_o,
   output logic                 rvalid_o,
   input  logic                 rready_i,
   output logic [63:0]          exit_o,
   output logic [63:0]          event_trigger_o
);

   localparam logic [63:0] DRAM_END = DRAMBase + DRAMLength;

   logic [AddrWidth-1:0] w_addr;
   logic [63:0]          w_data;
   logic [7:0]           w_strb;
   logic                 w_fire;
   logic [1:0]           w_widx;
   logic [1:0]           w_ridx;
   logic [63:0]          w_old;
   logic [63:0]          w_merged;
   logic [63:0]          w_rd_val;
   logic [63:0]          w_event_val;
   logic                 w_exit_we;
   axi_resp_t            w_bresp;
   axi_resp_t            r_bresp;
   logic [63:0]          r_exit;
   logic [63:0]          r_cycle;
   logic [63:0]          r_rdata;
   r_state_t             r_rstate;
   r_state_t             w_rstate_next;
   logic                 w_ar_hs;
   logic                 w_unused;

   ara_eoc_wjoin #(
      .AddrWidth (AddrWidth)
   ) u_wjoin (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .awaddr_i  (awaddr_i),
      .awvalid_i (awvalid_i),
      .awready_o (awready_o),
      .wdata_i   (wdata_i),
      .wstrb_i   (wstrb_i),
      .wvalid_i  (wvalid_i),
      .wready_o  (wready_o),
      .bvalid_o  (bvalid_o),
      .bready_i  (bready_i),
      .addr_o    (w_addr),
      .data_o    (w_data),
      .strb_o    (w_strb),
      .fire_o    (w_fire)
   );

   assign w_widx   = w_addr[4:3];
   assign w_ridx   = araddr_i[4:3];
   // Address bits outside [4:3] are don't-care for decode
   assign w_unused = ^{w_addr[AddrWidth-1:5], w_addr[2:0],
                       araddr_i[AddrWidth-1:5], araddr_i[2:0]};

`ifdef ARA_EOC_EVENT_TRIGGER_EN
   logic        r_event;
   logic        w_event_we;
   logic [63:0] r_event_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_event_q <= '0;
      end else if (w_event_we) begin
         r_event_q <= w_merged;
      end
   end
   assign r_event     = 1'b1;
   assign w_event_val = r_event_q;
`else
   assign w_event_val = '0;
`endif
   assign event_trigger_o = w_event_val;

   // Current contents feeding the byte merge and the read mux
   always_comb begin
      w_old    = '0;
      w_rd_val = '0;
      case (w_widx)
         REG_EXIT:          w_old = r_exit;
         REG_EVENT_TRIGGER: w_old = w_event_val;
         REG_DRAM_END:      w_old = DRAM_END;
         default:           w_old = r_cycle;
      endcase
      case (w_ridx)
         REG_EXIT:          w_rd_val = r_exit;
         REG_EVENT_TRIGGER: w_rd_val = w_event_val;
         REG_DRAM_END:      w_rd_val = DRAM_END;
         default:           w_rd_val = r_cycle;
      endcase
   end

   genvar gi;
   for (gi = 0; gi < 8; gi++) begin : g_merge
      assign w_merged[gi*8 +: 8] = w_strb[gi] ? w_data[gi*8 +: 8] : w_old[gi*8 +: 8];
   end

   // Write decode: an all-zero strobe is a no-op that is always OKAY
   always_comb begin
      w_exit_we = 1'b0;
`ifdef ARA_EOC_EVENT_TRIGGER_EN
      w_event_we = 1'b0;
`endif
      w_bresp   = RESP_OKAY;
      if (w_fire && (w_strb != 8'h00)) begin
         case (w_widx)
            REG_EXIT: w_exit_we = !r_exit[0];   // sticky after done
`ifdef ARA_EOC_EVENT_TRIGGER_EN
            REG_EVENT_TRIGGER: w_event_we = r_event;
`else
            REG_EVENT_TRIGGER: w_bresp = RESP_SLVERR;
`endif
            default: w_bresp = RESP_SLVERR;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_exit  <= '0;
         r_cycle <= '0;
         r_bresp <= RESP_OKAY;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         if (w_exit_we) begin
            r_exit <= w_merged;
         end
         if (w_fire) begin
            r_bresp <= w_bresp;
         end
      end
   end

   assign exit_o  = r_exit;
   assign bresp_o = r_bresp;

   // Read channel
   assign arready_o = (r_rstate == R_IDLE);
   assign rvalid_o  = (r_rstate == R_RESP);
   assign w_ar_hs   = arvalid_i && arready_o;

   always_comb begin
      w_rstate_next = r_rstate;
      case (r_rstate)
         R_IDLE: if (arvalid_i) w_rstate_next = R_RESP;
         R_RESP: if (rready_i)  w_rstate_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
      end else begin
         r_rstate <= w_rstate_next;
         if (w_ar_hs) begin
            r_rdata <= w_rd_val;   // pre-write value on a same-edge update
         end
      end
   end

   assign rdata_o = r_rdata;
   assign rresp_o = RESP_OKAY;   // every read is accepted

endmodule

// File: doc/ara_eoc_regs.md
# ara_eoc_regs

Memory-mapped end-of-computation and control register responder in the Ara SoC, on an AXI4-Lite slave port off the system crossbar. Software running on the core writes a tohost word to signal completion; the block drives `exit_o`, the word the testbench samples to end simulation. It also drives `event_trigger_o`, the software VCD-dump trigger, and exposes read-only DRAM end and cycle-count registers.

## Interface
- `DRAMBase`, default 64'h8000_0000: DRAM base address.
- `DRAMLength`, default 64'h4000_0000: DRAM size in bytes.
- `AddrWidth`, default 64: AXI-Lite address width. Data width is fixed at 64.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `awaddr_i`  in  AddrWidth  write address.
- `awvalid_i` in 1; `awready_o` out 1: write-address handshake.
- `wdata_i`  in  64  write data.
- `wstrb_i`  in  8  byte strobes.
- `wvalid_i` in 1; `wready_o` out 1: write-data handshake.
- `bresp_o`  out  2  write response: 0 OKAY, 2 SLVERR.
- `bvalid_o` out 1; `bready_i` in 1: write-response handshake.
- `araddr_i`  in  AddrWidth  read address.
- `arvalid_i` in 1; `arready_o` out 1: read-address handshake.
- `rdata_o`  out  64  read data.
- `rresp_o`  out  2  read response.
- `rvalid_o` out 1; `rready_i` in 1: read-data handshake.
- `exit_o`  out  64  tohost word. Bit 0 means done; bits 63:1 hold the exit code.
- `event_trigger_o`  out  64  VCD trigger. 1 starts dumping; all-ones stops dumping.

## Operation
- Decode uses `addr[4:3]`. `addr[2:0]` and bits 5 and above are ignored.
  - 0x00 EXIT: RW.
  - 0x08 EVENT_TRIGGER: RW.
  - 0x10 DRAM_END: RO, value DRAMBase+DRAMLength.
  - 0x18 CYCLE: RO.
- Writes merge per byte under `wstrb_i`. A write with `wstrb_i`=0 gives OKAY and changes nothing.
- A write to an RO register gives SLVERR and changes nothing. All reads give OKAY.
- EXIT is sticky once `exit_o[0]`=1: later EXIT writes give OKAY but are ignored until reset.
- CYCLE is a free-running 64-bit counter. It increments every cycle from reset and wraps to 0 after all-ones.
- Write FSM states:
  - W_IDLE: AW and W are captured independently. `awready_o`=1 while AW is not yet held; `wready_o`=1 while W is not yet held.
  - When both are held, the register updates and the FSM moves to W_RESP.
  - W_RESP: `bvalid_o`=1 until `bready_i`, then back to W_IDLE with the holds cleared.
- Read FSM states:
  - R_IDLE: `arready_o`=1. On the handshake, `rdata_o`/`rresp_o` are registered and the FSM moves to R_RESP.
  - R_RESP: `rvalid_o`=1 until `rready_i`, then back to R_IDLE.
- Read and write channels are independent. If a read handshake and a register update occur on the same edge, the read returns the pre-write value.
- The CYCLE read value is the counter value at the AR handshake edge.

## Timing
- Reset values:
  - `awready_o`=`wready_o`=`arready_o`=1.
  - `bvalid_o`=`rvalid_o`=0.
  - `bresp_o`=`rresp_o`=0, `rdata_o`=0.
  - `exit_o`=0, `event_trigger_o`=0, CYCLE=0.
- Write with AW and W in the same cycle:
  - The register and output update at edge N.
  - `bvalid_o` rises after edge N.
  - Throughput is at most one write per 2 cycles.
- Write with AW and W in different cycles: the update and `bvalid_o` follow the edge that completes the second handshake.
- Read: `rvalid_o` rises one cycle after the AR handshake. Throughput is at most one read per 2 cycles.
- `exit_o` and `event_trigger_o` are registered outputs with no combinational path from any input.
- `bvalid_o`/`rvalid_o` and their payloads stay stable until accepted.
- Reset mid-transaction aborts all FSMs to idle and drops held AW/W without a response.

## Configuration
- Macro `ARA_EOC_EVENT_TRIGGER_EN`.
- Defined: EVENT_TRIGGER behaves as above.
- Undefined:
  - No EVENT_TRIGGER flop exists.
  - `event_trigger_o` is tied to 0.
  - Writes to 0x08 give SLVERR; reads of 0x08 return 0 with OKAY.

## Structure
- Package `ara_eoc_regs_pkg` holds:
  - register offsets;
  - the `axi_resp_t` encodings OKAY/SLVERR;
  - the VCD_TRIGGER_ON/OFF constants (64'h1, all-ones);
  - the write and read FSM state enums.
- One sub-module, `ara_eoc_wjoin`: the AW/W capture and join. It outputs the held address, data and strobes plus a `fire` pulse.
- Register file, counter and read mux live in the top.

## Test plan
- Write 0x00 = 64'h1 with wstrb 8'hFF, AW and W in the same cycle -> `exit_o`=1 one cycle after the handshake; `bvalid_o` with OKAY; a later write of 64'h7 is ignored and `exit_o` stays 1.
- Fresh reset, W two cycles before AW, EXIT data 64'h2A, wstrb 8'h01 -> `wready_o` drops after the W handshake; `exit_o`=64'h2A only after AW arrives; one B response.
- Read 0x10 with default parameters -> `rdata_o`=64'hC000_0000, OKAY. Write 0x10 -> SLVERR, and the value is unchanged on re-read.
- Hold `bready_i`/`rready_i` low for 5 cycles -> `bvalid_o`/`rvalid_o` and payloads stay stable; `awready_o`/`arready_o` stay 0 until accepted.
- Write EVENT_TRIGGER 64'h1 then all-ones -> `event_trigger_o` follows each write. Without the macro: `event_trigger_o` stays 0 and the write returns SLVERR.
- Two CYCLE reads 10 cycles apart -> difference 10. Same-edge EXIT write and EXIT read -> the read returns the old value 0.
